timeout_supervisor: RTL and testbench

Parametrised multi-channel maintenance/timeout supervisor. Each channel runs its own IDLE/MAINT/COUNT/ALARM state machine with an internal tick-driven timeout counter. Unlike the earlier single-channel controller, the counter is not external; a kick re-arms the channel, a pre-timeout warning is raised, and alarms are sticky until cleared per channel. It sits between the system tick prescaler and the alarm display/mux logic, and reports an aggregated alarm flag and a priority index.

---
 rtl/timeout_supervisor.sv | 131 +++++++++++++
 tb/tb_timeout_supervisor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timeout_supervisor.sv
// timeout_supervisor: multi-channel maintenance/timeout supervisor.
// Each channel runs IDLE/MAINT/COUNT/ALARM with an internal tick-driven
// timeout counter. A kick re-arms the channel, a warning window precedes
// the alarm, and alarms are sticky until cleared per channel. The block
// reports an aggregated alarm flag and the lowest alarming channel index.
module timeout_supervisor #(
  parameter int CH       = 4,
  parameter int TW       = 8,
  parameter int TIMEOUT  = 200,
  parameter int PRE_WARN = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   tick,
  input  logic [CH-1:0]                          ch_en,
  input  logic [CH-1:0]                          kick,
  input  logic [CH-1:0]                          clr,
  output logic [CH-1:0]                          maint,
  output logic [CH-1:0]                          warn,
  output logic [CH-1:0]                          alarm,
  output logic                                   any_alarm,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] alarm_idx,
  output logic [2*CH-1:0]                        state_o
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_VAL  = TW'(TIMEOUT);
  localparam logic [TW-1:0] WARN_AT = TW'(TIMEOUT - PRE_WARN);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MAINT = 2'b01,
    COUNT = 2'b10,
    ALARM = 2'b11
  } state_t;

  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [TW-1:0] cnt_q   [CH];
  logic [TW-1:0] cnt_d   [CH];

  // State and counter registers; reset forces every channel to IDLE, count 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-channel next-state and counter update.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (ch_en[i]) state_d[i] = kick[i] ? MAINT : COUNT;
        end
        MAINT: begin
          cnt_d[i]   = '0;
          state_d[i] = ch_en[i] ? COUNT : IDLE;
        end
        COUNT: begin
          // Kick outranks an expiring tick in the same cycle.
          if (!ch_en[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (kick[i]) begin
            state_d[i] = MAINT;
          end else if (tick && (cnt_q[i] == TO_LAST)) begin
            state_d[i] = ALARM;
            cnt_d[i]   = TO_VAL;
          end else if (tick) begin
            cnt_d[i] = cnt_q[i] + TW'(1);
          end
        end
        ALARM: begin
          cnt_d[i] = TO_VAL;
          if (clr[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output decode from registered state and count only.
  always_comb begin
    maint   = '0;
    warn    = '0;
    alarm   = '0;
    state_o = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      maint[i]          = (state_q[i] == MAINT);
      alarm[i]          = (state_q[i] == ALARM);
      warn[i]           = (state_q[i] == COUNT) && (cnt_q[i] >= WARN_AT);
      state_o[2*i +: 2] = state_q[i];
    end
  end

  // Lowest-index alarming channel; zero when none is in ALARM.
  always_comb begin
    logic found;
    found     = 1'b0;
    alarm_idx = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (!found && (state_q[i] == ALARM)) begin
        alarm_idx = IW'(i);
        found     = 1'b1;
      end
    end
  end

  assign any_alarm = |alarm;

endmodule

// File: tb/tb_timeout_supervisor.sv
// tb_timeout_supervisor: directed stimulus with a scoreboard queue of
// expected output vectors, compared by an independent monitor process.
module tb_timeout_supervisor;

  localparam int CH       = 4;
  localparam int TW       = 8;
  localparam int TIMEOUT  = 10;
  localparam int PRE_WARN = 3;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] C = 2'b10;
  localparam logic [1:0] A = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] ch_en, kick, clr;
  logic [3:0] maint, warn, alarm;
  logic       any_alarm;
  logic [1:0] alarm_idx;
  logic [7:0] state_o;

  timeout_supervisor #(
    .CH(CH),
    .TW(TW),
    .TIMEOUT(TIMEOUT),
    .PRE_WARN(PRE_WARN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .ch_en(ch_en),
    .kick(kick),
    .clr(clr),
    .maint(maint),
    .warn(warn),
    .alarm(alarm),
    .any_alarm(any_alarm),
    .alarm_idx(alarm_idx),
    .state_o(state_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    string           nm;
    longint unsigned due;
    logic [7:0]      st;
    logic [3:0]      mt;
    logic [3:0]      wn;
    logic [3:0]      al;
    logic            any;
    logic [1:0]      idx;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [7:0] S(input logic [1:0] s3, input logic [1:0] s2,
                                   input logic [1:0] s1, input logic [1:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  task automatic push(input string nm, input longint unsigned due, input logic [7:0] st,
                      input logic [3:0] wn, input logic [1:0] idx);
    exp_t e;
    e.nm  = nm;
    e.due = due;
    e.st  = st;
    e.wn  = wn;
    e.idx = idx;
    for (int i = 0; i < 4; i++) begin
      e.mt[i] = (st[2*i +: 2] == M);
      e.al[i] = (st[2*i +: 2] == A);
    end
    e.any = |e.al;
    q.push_back(e);
  endtask

  // Called at a falling edge with inputs already driven; expectation applies
  // to the sample taken 1 time unit after the next rising edge.
  task automatic expect_edge(input string nm, input logic [7:0] st,
                             input logic [3:0] wn, input logic [1:0] idx);
    push(nm, longint'($time) + 6, st, wn, idx);
    @(negedge clk);
  endtask

  // Monitor: samples after every rising edge and after reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      while (q.size() > 0 && q[0].due <= longint'($time)) begin
        e = q.pop_front();
        checks++;
        if (e.due != longint'($time) || state_o !== e.st || maint !== e.mt ||
            warn !== e.wn || alarm !== e.al || any_alarm !== e.any || alarm_idx !== e.idx) begin
          errors++;
          $display("FAIL %s t=%0t: got state_o=%h maint=%b warn=%b alarm=%b any=%b idx=%0d; want state_o=%h maint=%b warn=%b alarm=%b any=%b idx=%0d (due %0d)",
                   e.nm, $time, state_o, maint, warn, alarm, any_alarm, alarm_idx,
                   e.st, e.mt, e.wn, e.al, e.any, e.idx, e.due);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int last;
    rst   = 1'b0;
    tick  = 1'b0;
    ch_en = '0;
    kick  = '0;
    clr   = '0;

    @(negedge clk);
    expect_edge("reset_hold", 8'h00, 4'h0, 2'd0);
    rst = 1'b1;
    expect_edge("idle_after_release", 8'h00, 4'h0, 2'd0);

    // Timeout path on ch0.
    ch_en = 4'b0001;
    tick  = 1'b1;
    for (int k = 1; k <= 13; k++)
      expect_edge("timeout_path", (k <= 10) ? S(I, I, I, C) : S(I, I, I, A),
                  (k >= 8 && k <= 10) ? 4'b0001 : 4'b0000, 2'd0);
    clr = 4'b0001;
    expect_edge("clr_to_idle", S(I, I, I, I), 4'h0, 2'd0);
    clr = 4'b0000;
    expect_edge("idle_to_count", S(I, I, I, C), 4'h0, 2'd0);
    ch_en = 4'b0000;
    expect_edge("disable_count", S(I, I, I, I), 4'h0, 2'd0);

    // Kick every 6 cycles keeps ch0 alive; after kicks stop it times out.
    ch_en = 4'b0001;
    for (int k = 1; k <= 107; k++) begin
      kick = (k <= 100 && (k % 6) == 0) ? 4'b0001 : 4'b0000;
      if (kick[0]) begin
        expect_edge("kick_maint", S(I, I, I, M), 4'h0, 2'd0);
      end else begin
        last = (k <= 100) ? (k / 6) * 6 : 96;
        c    = k - last - 1;
        expect_edge("kick_alive", (c >= 10) ? S(I, I, I, A) : S(I, I, I, C),
                    (c >= 7 && c < 10) ? 4'b0001 : 4'b0000, 2'd0);
      end
    end
    kick  = 4'b0000;
    clr   = 4'b0001;
    ch_en = 4'b0000;
    expect_edge("kick_clr", S(I, I, I, I), 4'h0, 2'd0);
    clr = 4'b0000;

    // Kick and expiring tick in the same cycle.
    ch_en = 4'b0001;
    for (int k = 1; k <= 10; k++)
      expect_edge("collision_count", S(I, I, I, C), (k >= 8) ? 4'b0001 : 4'b0000, 2'd0);
    kick = 4'b0001;
    expect_edge("collision_maint", S(I, I, I, M), 4'h0, 2'd0);
    kick = 4'b0000;
    expect_edge("collision_rearm", S(I, I, I, C), 4'h0, 2'd0);
    ch_en = 4'b0000;
    expect_edge("collision_idle", S(I, I, I, I), 4'h0, 2'd0);

    // Priority index: ch2 alarms first, then ch1.
    ch_en = 4'b0100;
    for (int k = 1; k <= 15; k++) begin
      logic [1:0] s1, s2, ix;
      logic [3:0] w;
      if (k == 4) ch_en = 4'b0110;
      s2 = (k >= 11) ? A : C;
      s1 = (k < 4) ? I : ((k >= 14) ? A : C);
      w  = 4'b0000;
      if (k >= 8 && k <= 10) w[2] = 1'b1;
      if (k >= 11 && k <= 13) w[1] = 1'b1;
      ix = (k >= 14) ? 2'd1 : ((k >= 11) ? 2'd2 : 2'd0);
      expect_edge("prio_run", S(I, s2, s1, I), w, ix);
    end
    ch_en = 4'b0000;
    kick  = 4'b0110;
    expect_edge("prio_ignore", S(I, A, A, I), 4'h0, 2'd1);
    kick = 4'b0000;
    clr  = 4'b0010;
    expect_edge("prio_clr1", S(I, A, I, I), 4'h0, 2'd2);
    clr = 4'b0100;
    expect_edge("prio_clr2", S(I, I, I, I), 4'h0, 2'd0);
    clr = 4'b0000;

    // Gating: tick=0 holds the count; ch_en=0 resets it; ALARM ignores ch_en.
    ch_en = 4'b0001;
    for (int k = 1; k <= 5; k++) expect_edge("gate_pre", S(I, I, I, C), 4'h0, 2'd0);
    tick = 1'b0;
    for (int k = 1; k <= 20; k++) expect_edge("gate_hold", S(I, I, I, C), 4'h0, 2'd0);
    tick = 1'b1;
    for (int k = 1; k <= 3; k++)
      expect_edge("gate_resume", S(I, I, I, C), (k == 3) ? 4'b0001 : 4'b0000, 2'd0);
    ch_en = 4'b0000;
    expect_edge("gate_drop", S(I, I, I, I), 4'h0, 2'd0);
    ch_en = 4'b0001;
    for (int k = 1; k <= 11; k++)
      expect_edge("gate_restart", (k <= 10) ? S(I, I, I, C) : S(I, I, I, A),
                  (k >= 8 && k <= 10) ? 4'b0001 : 4'b0000, 2'd0);
    ch_en = 4'b0000;
    kick  = 4'b0001;
    for (int k = 1; k <= 3; k++) expect_edge("alarm_sticky", S(I, I, I, A), 4'h0, 2'd0);
    kick = 4'b0000;
    clr  = 4'b0001;
    expect_edge("gate_clr", S(I, I, I, I), 4'h0, 2'd0);
    clr = 4'b0000;

    // Async reset with ch0 in ALARM and ch1 at count 5.
    ch_en = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      if (k == 7) ch_en = 4'b0011;
      expect_edge("pre_reset", S(I, I, (k >= 7) ? C : I, (k >= 11) ? A : C),
                  (k >= 8 && k <= 10) ? 4'b0001 : 4'b0000, 2'd0);
    end
    rst = 1'b0;
    push("async_reset", longint'($time) + 1, 8'h00, 4'h0, 2'd0);
    @(negedge clk);
    expect_edge("reset_held", 8'h00, 4'h0, 2'd0);
    rst = 1'b1;
    expect_edge("release_from_idle", S(I, I, C, C), 4'h0, 2'd0);
    ch_en = 4'b0000;
    expect_edge("final_idle", S(I, I, I, I), 4'h0, 2'd0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never sampled, want 0", q.size());
      errors += q.size();
      checks += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
